uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter word_width, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter reductor_width, default 4, meaning one bit time equals 2^reductor_width clk cycles; legal values are 2 or greater.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data_in, input, word_width bits: word to transmit.
REQ-006 SHALL have port data_valid, input, 1 bit: data_in is offered.
REQ-007 SHALL have port data_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 SHALL have port stopbitnum, input, 2 bits: 0 gives 1 stop bit, 1 gives 1.5, 2 gives 2, and 3 is treated as 1.
REQ-009 SHALL have port paritytype, input, 3 bits: 0 none, 1 odd, 2 even, 3 space, 4 mark; 5 to 7 are treated as none.
REQ-010 SHALL have port busy, output, 1 bit: a frame or break is in progress.
REQ-011 SHALL have port tx_state, output, 3 bits: the current FSM state encoding.
REQ-012 SHALL have port TX, output, 1 bit: serial line, idle high.

Function
REQ-013 SHALL implement the FSM states IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 and BREAK=5.
REQ-014 SHALL raise data_ready only in IDLE with reset low; a transfer occurs on a rising clk edge where data_valid and data_ready are both high.
REQ-015 SHALL latch data_in, stopbitnum and paritytype on transfer; later changes to these inputs do not affect the frame in flight.
REQ-016 SHALL, on transfer, enter START on the next cycle; TX is 0 for exactly 2^reductor_width cycles starting that cycle.
REQ-017 SHALL send DATA LSB first, each bit for exactly 2^reductor_width cycles, using an internal bit counter that wraps after word_width bits.
REQ-018 SHALL, after DATA, go to PARITY when the latched parity is not none, else go to STOP.
REQ-019 SHALL drive the PARITY bit for one bit time as follows: odd gives ~^word, even gives ^word, space gives 0, mark gives 1.
REQ-020 SHALL hold TX at 1 during STOP for 1, 1.5 or 2 bit times, i.e. 2^R, 1.5*2^R or 2*2^R cycles.
REQ-021 SHALL return to IDLE on the cycle after the last STOP cycle, with data_ready high that cycle.
REQ-022 SHALL, when data_valid is already high, start the next frame's START bit immediately after that IDLE cycle; the only gap is that single IDLE cycle of TX=1.
REQ-023 SHALL drive busy=1 in every state except IDLE.
REQ-024 SHALL drive tx_state equal to the current state.
REQ-025 SHALL register TX with no combinational path from inputs to TX.
REQ-026 SHALL restart the bit-time counter from 0 at every state entry and not let it free-run.

Reset
REQ-027 SHALL, while reset=1, give the following at the next edge: state IDLE, TX=1, busy=0, data_ready=0, counters 0.
REQ-028 SHALL abort any frame when reset is asserted mid-frame; TX goes to 1 on the next cycle and no partial resume occurs.
REQ-029 SHALL raise data_ready on the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, when UART_TX_BREAK_EN is defined, add an input port send_break of 1 bit and enable BREAK.
REQ-031 SHALL, in IDLE with send_break=1, enter BREAK, giving send_break priority over data_valid; TX=0 while send_break stays high, for at least (word_width+3)*2^R cycles.
REQ-032 SHALL, on exit from BREAK, hold TX=1 for one bit time of mark and then return to IDLE.
REQ-033 SHALL, without UART_TX_BREAK_EN, have no send_break port and no BREAK state logic; encoding 5 is never produced.

Verification
All scenarios use word_width=8 and reductor_width=4, giving 16 clocks per bit.
REQ-034 SHALL cover: 0xA5, no parity, 1 stop -> TX bits 0,1,0,1,0,0,1,0,1,1, 16 clocks each; data_ready returns 161 clocks after transfer.
REQ-035 SHALL cover: 0x03, odd parity -> parity bit 1; 0x07, even parity -> parity bit 1; 0x00, mark parity -> parity bit 1.
REQ-036 SHALL cover: 0x55, stopbitnum=1 -> stop high for 24 clocks; stopbitnum=2 -> 32 clocks; stopbitnum=3 -> 16 clocks.
REQ-037 SHALL cover: data_valid held high with 0x11 then 0x22 -> two frames separated by exactly one IDLE cycle; data_in changes mid-frame are ignored.
REQ-038 SHALL cover: reset pulsed during DATA bit 3 -> TX=1 next cycle, busy=0, data_ready=1 on the first cycle after reset falls.
REQ-039 SHALL cover, with UART_TX_BREAK_EN: send_break high for 50 clocks with data_valid high -> TX low for 176 clocks, then high for 16 clocks, then the pending word is accepted.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter, LSB-first framing with optional parity
// and 1 / 1.5 / 2 stop bits. One bit time is 2**reductor_width clk cycles.
// Optional feature: define UART_TX_BREAK_EN to add the send_break input and
// the BREAK state (line held low, followed by one bit time of mark).
`timescale 1ns/1ps
module uart_tx_serializer #(
  parameter int word_width     = 8,
  parameter int reductor_width = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [word_width-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [1:0]            stopbitnum,
  input  logic [2:0]            paritytype,
`ifdef UART_TX_BREAK_EN
  input  logic                  send_break,
`endif
  output logic                  busy,
  output logic [2:0]            tx_state,
  output logic                  TX
);

  localparam int BIT_CYCLES = 2 ** reductor_width;
`ifdef UART_TX_BREAK_EN
  // Counter must also span the minimum break length.
  localparam int CNT_LIMIT  = (word_width + 3) * BIT_CYCLES;
`else
  // Longest timed interval is two stop bits.
  localparam int CNT_LIMIT  = 2 * BIT_CYCLES;
`endif
  localparam int CNT_W      = $clog2(CNT_LIMIT);
  localparam int IDX_W      = (word_width > 1) ? $clog2(word_width) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LAST_15 = CNT_W'(BIT_CYCLES + BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST_2  = CNT_W'(2 * BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] WORD_LAST    = IDX_W'(word_width - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [CNT_W-1:0] BREAK_LAST   = CNT_W'(CNT_LIMIT - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    , ST_BREAK = 3'd5
`endif
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        bit_reg, bit_next;
  logic [IDX_W-1:0]        bit_inc;
  logic [word_width-1:0]   word_reg, word_next;
  logic [1:0]              stop_reg, stop_next;
  logic [2:0]              par_reg, par_next;
  logic                    tx_reg, tx_next;
  logic [CNT_W-1:0]        stop_last;
  logic                    par_en;
  logic                    parity_bit;
`ifdef UART_TX_BREAK_EN
  logic                    mark_reg, mark_next;
`endif

  assign busy     = (state_reg != ST_IDLE);
  assign tx_state = state_reg;
  assign TX       = tx_reg;
  assign bit_inc  = bit_reg + 1'b1;
  assign par_en   = (par_reg >= 3'd1) && (par_reg <= 3'd4);

`ifdef UART_TX_BREAK_EN
  // A pending break request wins over a pending word.
  assign data_ready = (state_reg == ST_IDLE) && !reset && !send_break;
`else
  assign data_ready = (state_reg == ST_IDLE) && !reset;
`endif

  // Last counter value of the stop interval for the latched stop setting.
  always_comb begin
    case (stop_reg)
      2'd1:    stop_last = STOP_LAST_15;
      2'd2:    stop_last = STOP_LAST_2;
      default: stop_last = BIT_LAST;
    endcase
  end

  // Parity bit value for the latched word and parity type.
  always_comb begin
    case (par_reg)
      3'd1:    parity_bit = ~^word_reg;
      3'd2:    parity_bit = ^word_reg;
      3'd3:    parity_bit = 1'b0;
      3'd4:    parity_bit = 1'b1;
      default: parity_bit = 1'b0;
    endcase
  end

  // Next-state logic; tx_next is the line level for the coming cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    word_next  = word_reg;
    stop_next  = stop_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
`ifdef UART_TX_BREAK_EN
    mark_next  = mark_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        tx_next  = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          state_next = ST_BREAK;
          mark_next  = 1'b0;
          tx_next    = 1'b0;
        end else
`endif
        if (data_valid) begin
          state_next = ST_START;
          word_next  = data_in;
          stop_next  = stopbitnum;
          par_next   = paritytype;
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        tx_next = 1'b0;
        if (cnt_reg == BIT_LAST) begin
          state_next = ST_DATA;
          cnt_next   = '0;
          bit_next   = '0;
          tx_next    = word_reg[0];
        end
      end
      ST_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (bit_reg == WORD_LAST) begin
            bit_next = '0;
            if (par_en) begin
              state_next = ST_PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_inc;
            tx_next  = word_reg[bit_inc];
          end
        end
      end
      ST_PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          state_next = ST_STOP;
          cnt_next   = '0;
          tx_next    = 1'b1;
        end
      end
      ST_STOP: begin
        tx_next = 1'b1;
        if (cnt_reg == stop_last) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!mark_reg) begin
          tx_next = 1'b0;
          if (cnt_reg >= BREAK_LAST) begin
            if (send_break) begin
              cnt_next = cnt_reg;
            end else begin
              mark_next = 1'b1;
              cnt_next  = '0;
              tx_next   = 1'b1;
            end
          end
        end else begin
          tx_next = 1'b1;
          if (cnt_reg == BIT_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            mark_next  = 1'b0;
          end
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

  // State, counters, latched frame settings and the registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      word_reg  <= '0;
      stop_reg  <= '0;
      par_reg   <= '0;
      tx_reg    <= 1'b1;
`ifdef UART_TX_BREAK_EN
      mark_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      word_reg  <= word_next;
      stop_reg  <= stop_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
`ifdef UART_TX_BREAK_EN
      mark_reg  <= mark_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: stimulus pushes expected frames into a scoreboard;
// a monitor decodes the serial line cycle by cycle against a bit-time model.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [1:0] stopbitnum;
  logic [2:0] paritytype;
  logic       busy;
  logic [2:0] tx_state;
  logic       TX;
`ifdef UART_TX_BREAK_EN
  logic       send_break;
`endif

  uart_tx_serializer #(.word_width(8), .reductor_width(4)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .stopbitnum(stopbitnum),
    .paritytype(paritytype),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .busy(busy),
    .tx_state(tx_state),
    .TX(TX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    int         par;
    int         stop;
  } frame_t;

  frame_t sb[$];
  int     errors = 0;
  int     checks = 0;
  bit     mon_active = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // ---------------- reference model (bit-time arithmetic) ----------------
  localparam int T = 16;

  function automatic int stop_cycles(input int s);
    if (s == 1) return 24;
    if (s == 2) return 32;
    return 16;
  endfunction

  function automatic int has_par(input int p);
    return (p >= 1 && p <= 4) ? 1 : 0;
  endfunction

  function automatic int frame_len(input frame_t f);
    return T * (1 + 8 + has_par(f.par)) + stop_cycles(f.stop);
  endfunction

  function automatic logic par_value(input frame_t f);
    int ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(f.word[k]);
    case (f.par)
      1: return ((ones % 2) == 0) ? 1'b1 : 1'b0;
      2: return ((ones % 2) == 1) ? 1'b1 : 1'b0;
      3: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic ref_tx(input frame_t f, input int i);
    int slot = i / T;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return f.word[slot-1];
    if (slot == 9 && has_par(f.par) == 1) return par_value(f);
    return 1'b1;
  endfunction

  function automatic int ref_state(input frame_t f, input int i);
    int slot = i / T;
    if (slot == 0) return 1;
    if (slot <= 8) return 2;
    if (slot == 9 && has_par(f.par) == 1) return 3;
    return 4;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    frame_t f;
    int len, bad_tx, bad_st, bad_bz, bad_rd, first_bad;
    bit aborted;
    forever begin
      @(negedge clk);
      while (data_ready && data_valid && !reset) begin
        mon_active = 1;
        if (sb.size() == 0) begin
          check("scoreboard_empty_at_transfer", 0, 1);
          mon_active = 0;
          break;
        end
        f = sb.pop_front();
        len = frame_len(f);
        bad_tx = 0; bad_st = 0; bad_bz = 0; bad_rd = 0; first_bad = -1;
        aborted = 0;
        for (int i = 0; i < len; i++) begin
          @(negedge clk);
          if (reset) begin aborted = 1; break; end
          if (TX !== ref_tx(f, i)) begin
            bad_tx++;
            if (first_bad < 0) first_bad = i;
          end
          if (int'(tx_state) != ref_state(f, i)) bad_st++;
          if (busy !== 1'b1) bad_bz++;
          if (data_ready !== 1'b0) bad_rd++;
        end
        if (aborted) begin
          $display("frame word=%02h parity=%0d stop=%0d aborted by reset", f.word, f.par, f.stop);
          mon_active = 0;
          break;
        end
        check("frame_tx_bad_cycles", bad_tx, 0);
        if (bad_tx != 0) $display("  first bad TX cycle %0d of word %02h", first_bad, f.word);
        check("frame_state_bad_cycles", bad_st, 0);
        check("frame_busy_bad_cycles", bad_bz, 0);
        check("frame_ready_bad_cycles", bad_rd, 0);
        // Cycle len+1 after the transfer cycle: back in IDLE.
        @(negedge clk);
        if (!reset) begin
          check("end_ready", int'(data_ready), 1);
          check("end_busy", int'(busy), 0);
          check("end_tx", int'(TX), 1);
          check("end_state", int'(tx_state), 0);
        end
        $display("frame word=%02h parity=%0d stop=%0d cycles=%0d", f.word, f.par, f.stop, len);
        mon_active = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (data_ready) begin ok = 1; break; end
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] w, input int p, input int s, input bit keep);
    frame_t f;
    bit ok;
    f.word = w; f.par = p; f.stop = s;
    data_in    = w;
    paritytype = p[2:0];
    stopbitnum = s[1:0];
    data_valid = 1'b1;
    sb.push_back(f);
    wait_ready(ok);
    if (!ok) begin
      data_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk); #1;
    if (!keep) data_valid = 1'b0;
    // Scramble the inputs mid-frame; the frame in flight must not change.
    repeat (40) begin
      @(posedge clk); #1;
      data_in    = 8'($urandom);
      paritytype = 3'($urandom);
      stopbitnum = 2'($urandom);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mon_active && !busy) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    reset      = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    stopbitnum = 2'd0;
    paritytype = 3'd0;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(data_ready), 0);
    check("reset_tx", int'(TX), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_state", int'(tx_state), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", int'(data_ready), 1);

    // Directed frames.
    send(8'hA5, 0, 0, 0);
    send(8'h03, 1, 0, 0);
    send(8'h07, 2, 0, 0);
    send(8'h00, 4, 0, 0);
    send(8'hFF, 3, 0, 0);
    send(8'h55, 0, 1, 0);
    send(8'h55, 0, 2, 0);
    send(8'h55, 0, 3, 0);
    send(8'h3C, 6, 0, 0);
    wait_idle();

    // Back-to-back with data_valid held high.
    send(8'h11, 0, 0, 1);
    send(8'h22, 0, 0, 0);
    wait_idle();

    // Reset pulsed during DATA bit 3.
    begin
      frame_t f;
      bit ok;
      f.word = 8'hC3; f.par = 0; f.stop = 0;
      data_in = 8'hC3; paritytype = 3'd0; stopbitnum = 2'd0; data_valid = 1'b1;
      sb.push_back(f);
      wait_ready(ok);
      @(posedge clk); #1;
      data_valid = 1'b0;
      repeat (70) @(posedge clk);
      #1;
      check("pre_reset_in_data", int'(tx_state), 2);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_tx", int'(TX), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_ready_in_reset", int'(data_ready), 0);
      check("abort_state", int'(tx_state), 0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_ready_after", int'(data_ready), 1);
      $display("reset abort word=C3 done");
    end
    wait_idle();

`ifdef UART_TX_BREAK_EN
    begin
      frame_t f;
      int lo, hi, cyc;
      f.word = 8'h5A; f.par = 0; f.stop = 0;
      @(posedge clk); #1;
      send_break = 1'b1;
      data_in = 8'h5A; paritytype = 3'd0; stopbitnum = 2'd0; data_valid = 1'b1;
      sb.push_back(f);
      @(posedge clk);
      lo = 0; cyc = 0;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) check("break_state", int'(tx_state), 5);
        if (cyc == 50) send_break = 1'b0;
        if (TX == 1'b0) lo++;
        else break;
      end
      hi = 0;
      for (int k = 0; k < 100; k++) begin
        if (!busy || TX !== 1'b1) break;
        hi++;
        @(negedge clk);
      end
      check("break_low_cycles", lo, 176);
      check("break_mark_cycles", hi, 16);
      check("break_then_ready", int'(data_ready), 1);
      $display("break low=%0d mark=%0d", lo, hi);
      @(posedge clk); #1;
      data_valid = 1'b0;
    end
    wait_idle();
`endif

    // Randomized frames.
    for (int n = 0; n < 12; n++) begin
      send(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           (n == 11) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    data_valid = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
